imm_ext_pipe: RTL and testbench

IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

---
 rtl/imm_pkg.sv | 30 +++
 rtl/imm_decode.sv | 57 +++++
 rtl/imm_ext_pipe.sv | 98 +++++++++
 tb/tb_imm_ext_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension pipeline: format encoding,
// major-opcode (inst[6:2]) constants and the datapath-width legality check.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } imm_fmt_e;

  localparam logic [4:0] OP_LOAD    = 5'b00000;
  localparam logic [4:0] OP_OP_IMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC   = 5'b00101;
  localparam logic [4:0] OP_IMM_32  = 5'b00110;
  localparam logic [4:0] OP_STORE   = 5'b01000;
  localparam logic [4:0] OP_LUI     = 5'b01101;
  localparam logic [4:0] OP_BRANCH  = 5'b11000;
  localparam logic [4:0] OP_JALR    = 5'b11001;
  localparam logic [4:0] OP_JAL     = 5'b11011;
  localparam logic [4:0] OP_SYSTEM  = 5'b11100;

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder.
// Ports: inst   - raw 32-bit instruction word
//        imm    - immediate extended to XLEN (0 for NONE / illegal)
//        fmt    - decoded immediate format
//        illegal- inst[1:0] != 2'b11 (compressed or invalid encoding)
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int EN_ZIMM = 1
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  // Built at 64 bits for every XLEN and truncated, so the U-format sign
  // extension needs no zero-width replication when XLEN=32.
  logic [63:0] wide;

  assign illegal = (inst[1:0] != 2'b11);

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block can leave it holding state (a latch).
  always_comb begin
    fmt = FMT_NONE;
    if (!illegal) begin
      case (inst[6:2])
        OP_LOAD, OP_OP_IMM, OP_JALR: fmt = FMT_I;
        OP_IMM_32:                   if (XLEN == 64) fmt = FMT_I;
        OP_STORE:                    fmt = FMT_S;
        OP_BRANCH:                   fmt = FMT_B;
        OP_LUI, OP_AUIPC:            fmt = FMT_U;
        OP_JAL:                      fmt = FMT_J;
        OP_SYSTEM:                   if ((EN_ZIMM != 0) && inst[14]) fmt = FMT_Z;
        default:                     fmt = FMT_NONE;
      endcase
    end
  end

  always_comb begin
    wide = '0;
    case (fmt)
      FMT_I: wide = {{52{inst[31]}}, inst[31:20]};
      FMT_S: wide = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B: wide = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U: wide = {{32{inst[31]}}, inst[31:12], 12'b0};
      FMT_J: wide = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      FMT_Z: wide = {59'b0, inst[19:15]};
      default: wide = '0;
    endcase
  end

  assign imm = wide[XLEN-1:0];

endmodule

// File: rtl/imm_ext_pipe.sv
// Immediate-extension pipeline: decodes the incoming instruction and holds
// the decoded result in a 2-entry FIFO (skid buffer) with valid/ready on
// both sides. Latency is one cycle from the accepting edge to out_valid.
// Ports: clk, rst_n (async active-low), flush (drop all entries),
//        in_valid/in_ready/in_inst   - upstream handshake and instruction
//        out_valid/out_ready         - downstream handshake
//        out_imm/out_fmt/out_inst/out_illegal - head entry of the FIFO
module imm_ext_pipe
  import imm_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int EN_ZIMM = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [31:0]     out_inst,
  output logic            out_illegal
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_ext_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_fmt_e        fmt;
    logic [31:0]     inst;
    logic            illegal;
  } entry_t;

  entry_t     dec;
  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  imm_decode #(
    .XLEN    (XLEN),
    .EN_ZIMM (EN_ZIMM)
  ) u_decode (
    .inst    (in_inst),
    .imm     (dec.imm),
    .fmt     (dec.fmt),
    .illegal (dec.illegal)
  );
  assign dec.inst = in_inst;

  // Ready depends only on the registered count, so no combinational path
  // exists from in_valid or out_ready to in_ready.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // NOTE: the two storage entries are reset too, because the output fields
  // read the head entry directly and must be zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update based on
      // pre-edge values, whatever order the statements appear in.
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_imm     = mem[rd_ptr].imm;
  assign out_fmt     = mem[rd_ptr].fmt;
  assign out_inst    = mem[rd_ptr].inst;
  assign out_illegal = mem[rd_ptr].illegal;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: three instances (XLEN=32, XLEN=64, XLEN=32 with
// EN_ZIMM=0) share one stimulus stream; each has its own expected queue.
module tb_imm_ext_pipe;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;

  logic        rdy_a, vld_a, ill_a, rdy_b, vld_b, ill_b, rdy_c, vld_c, ill_c;
  logic [31:0] imm_a, imm_c, inst_a, inst_b, inst_c;
  logic [63:0] imm_b;
  logic [2:0]  fmt_a, fmt_b, fmt_c;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.XLEN(32), .EN_ZIMM(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_inst(in_inst), .out_valid(vld_a), .out_ready(out_ready), .out_imm(imm_a),
    .out_fmt(fmt_a), .out_inst(inst_a), .out_illegal(ill_a));

  imm_ext_pipe #(.XLEN(64), .EN_ZIMM(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .in_inst(in_inst), .out_valid(vld_b), .out_ready(out_ready), .out_imm(imm_b),
    .out_fmt(fmt_b), .out_inst(inst_b), .out_illegal(ill_b));

  imm_ext_pipe #(.XLEN(32), .EN_ZIMM(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .in_inst(in_inst), .out_valid(vld_c), .out_ready(out_ready), .out_imm(imm_c),
    .out_fmt(fmt_c), .out_inst(inst_c), .out_illegal(ill_c));

  // Reference model written from the instruction-set field layouts.
  function automatic exp_t model(input logic [31:0] inst, input int xlen, input int zimm);
    exp_t e;
    logic signed [63:0] s;
    logic [11:0] f12;
    logic [12:0] f13;
    logic [20:0] f21;
    e.inst = inst;
    e.imm  = 64'd0;
    e.fmt  = 3'd0;
    e.ill  = (inst[1:0] != 2'b11);
    s      = 64'sd0;
    if (!e.ill) begin
      case (inst[6:2])
        5'b00000, 5'b00100, 5'b11001: begin e.fmt = 3'd1; f12 = inst[31:20]; s = $signed(f12); end
        5'b00110: if (xlen == 64) begin e.fmt = 3'd1; f12 = inst[31:20]; s = $signed(f12); end
        5'b01000: begin e.fmt = 3'd2; f12 = {inst[31:25], inst[11:7]}; s = $signed(f12); end
        5'b11000: begin
          e.fmt = 3'd3; f13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; s = $signed(f13);
        end
        5'b01101, 5'b00101: begin e.fmt = 3'd4; s = $signed({inst[31:12], 12'h000}); end
        5'b11011: begin
          e.fmt = 3'd5; f21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; s = $signed(f21);
        end
        5'b11100: if (zimm != 0 && inst[14]) begin e.fmt = 3'd6; s = {59'd0, inst[19:15]}; end
        default: ;
      endcase
    end
    e.imm = s;
    if (xlen == 32) e.imm = {32'd0, e.imm[31:0]};
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_head(input string p, input exp_t e, input logic [63:0] imm,
                            input logic [2:0] fmt, input logic [31:0] inst, input logic ill);
    check({p, ".imm"}, imm, e.imm);
    check({p, ".fmt"}, {61'd0, fmt}, {61'd0, e.fmt});
    check({p, ".inst"}, {32'd0, inst}, {32'd0, e.inst});
    check({p, ".illegal"}, {63'd0, ill}, {63'd0, e.ill});
  endtask

  task automatic check_idle(input string p);
    check({p, ".a.out_valid"}, {63'd0, vld_a}, 64'd0);
    check({p, ".a.in_ready"}, {63'd0, rdy_a}, 64'd1);
    check({p, ".b.out_valid"}, {63'd0, vld_b}, 64'd0);
    check({p, ".c.in_ready"}, {63'd0, rdy_c}, 64'd1);
  endtask

  // One cycle: drive inputs (called just after a falling edge), check the
  // handshake and head fields against the queues, update the queues by the
  // model's view of push/pop, then advance to the next falling edge.
  task automatic step(input logic v, input logic [31:0] inst, input logic rdy, input logic fl);
    bit can_push;
    bit can_pop;
    in_valid  = v;
    in_inst   = inst;
    out_ready = rdy;
    flush     = fl;
    #1;
    check("a.in_ready", {63'd0, rdy_a}, {63'd0, q_a.size() < 2});
    check("b.in_ready", {63'd0, rdy_b}, {63'd0, q_b.size() < 2});
    check("c.in_ready", {63'd0, rdy_c}, {63'd0, q_c.size() < 2});
    check("a.out_valid", {63'd0, vld_a}, {63'd0, q_a.size() != 0});
    check("b.out_valid", {63'd0, vld_b}, {63'd0, q_b.size() != 0});
    check("c.out_valid", {63'd0, vld_c}, {63'd0, q_c.size() != 0});
    if (q_a.size() != 0) check_head("a", q_a[0], {32'd0, imm_a}, fmt_a, inst_a, ill_a);
    if (q_b.size() != 0) check_head("b", q_b[0], imm_b, fmt_b, inst_b, ill_b);
    if (q_c.size() != 0) check_head("c", q_c[0], {32'd0, imm_c}, fmt_c, inst_c, ill_c);
    can_push = v && (q_a.size() < 2);
    can_pop  = rdy && (q_a.size() != 0);
    if (fl) begin
      q_a.delete(); q_b.delete(); q_c.delete();
    end else begin
      if (can_pop) begin
        void'(q_a.pop_front()); void'(q_b.pop_front()); void'(q_c.pop_front());
      end
      if (can_push) begin
        q_a.push_back(model(inst, 32, 1));
        q_b.push_back(model(inst, 64, 1));
        q_c.push_back(model(inst, 32, 0));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 6 && q_a.size() != 0; i++) step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 32'd0, 1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_inst = 32'd0;
    #3;
    // Outputs must already be cleared before any clock edge.
    check_idle("rst_noclk");
    check("rst.a.imm", {32'd0, imm_a}, 64'd0);
    check("rst.b.imm", imm_b, 64'd0);
    check("rst.a.fmt", {61'd0, fmt_a}, 64'd0);
    check("rst.a.inst", {32'd0, inst_a}, 64'd0);
    check("rst.a.illegal", {63'd0, ill_a}, 64'd0);
    repeat (2) @(negedge clk);
    check_idle("rst_clk");
    rst_n = 1'b1;

    // First push lands on the first rising edge after release.
    step(1'b1, 32'hFFF00093, 1'b1, 1'b0);   // addi -1
    step(1'b1, 32'hFE112E23, 1'b1, 1'b0);   // sw -4
    step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);   // beq -4
    step(1'b1, 32'h300FD073, 1'b1, 1'b0);   // csrrwi zimm 31
    step(1'b1, 32'h30009073, 1'b1, 1'b0);   // csrrw (inst[14]=0) -> NONE
    step(1'b1, 32'h800000B7, 1'b1, 1'b0);   // lui 0x80000
    step(1'b1, 32'h0000001B, 1'b1, 1'b0);   // OP-IMM-32
    step(1'b1, 32'hFFDFF06F, 1'b1, 1'b0);   // jal -4
    step(1'b1, 32'h00001097, 1'b1, 1'b0);   // auipc 0x1
    step(1'b1, 32'h00000011, 1'b1, 1'b0);   // addi with inst[1:0]=01 -> illegal
    step(1'b1, 32'h7FF0A003, 1'b1, 1'b0);   // lw +2047
    drain();

    // Backpressure: three back-to-back pushes with out_ready low.
    step(1'b1, 32'hFFF00093, 1'b0, 1'b0);
    step(1'b1, 32'hFE112E23, 1'b0, 1'b0);
    step(1'b1, 32'hFE000EE3, 1'b0, 1'b0);   // refused, in_ready=0
    step(1'b1, 32'hFE000EE3, 1'b0, 1'b0);   // head must hold
    step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);   // pop only
    step(1'b1, 32'hFE000EE3, 1'b1, 1'b0);   // push + pop
    drain();

    // Flush with a full FIFO and a simultaneous push.
    step(1'b1, 32'h800000B7, 1'b0, 1'b0);
    step(1'b1, 32'h300FD073, 1'b0, 1'b0);
    step(1'b1, 32'h00000013, 1'b1, 1'b1);
    check_idle("post_flush");
    step(1'b0, 32'd0, 1'b1, 1'b0);

    // Asynchronous reset pulse with a full FIFO.
    step(1'b1, 32'hFFDFF06F, 1'b0, 1'b0);
    step(1'b1, 32'h0000001B, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst.b.imm", imm_b, 64'd0);
    q_a.delete(); q_b.delete(); q_c.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b1, 32'hFE112E23, 1'b1, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
